// File: rtl/alu_pkg.sv
// Shared encodings for the LEGv8 ALU sequencer: select codes, ALUOp values,
// R-type opcodes and the sequencer FSM state type.
// Pure declarations; no logic and no latency.
package alu_pkg;

    localparam int DATA_W = 64;

    // ALU control codes presented on select
    localparam logic [3:0] SEL_AND    = 4'b0000;
    localparam logic [3:0] SEL_OR     = 4'b0001;
    localparam logic [3:0] SEL_ADD    = 4'b0010;
    localparam logic [3:0] SEL_SUB    = 4'b0110;
    localparam logic [3:0] SEL_PASS_B = 4'b0111;
    // Defined by the ALU but never issued by this sequencer
    localparam logic [3:0] SEL_NOR    = 4'b1100;

    // ALUOp field encodings
    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_CBZ  = 2'b01;
    localparam logic [1:0] ALUOP_RTYP = 2'b10;

    // R-type opcodes, instruction bits [31:21]
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, external-ALU and response signals of the ALU sequencer.
// master = requester/ALU environment, slave = the sequencer.
// Valid/ready on both request and response sides.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        alu_op;
    logic [10:0]       opcode;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        select;
    logic [DATA_W-1:0] out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req_valid, alu_op, opcode, req_a, req_b, out, rsp_ready,
        input  req_ready, a, b, select, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, alu_op, opcode, req_a, req_b, out, rsp_ready,
        output req_ready, a, b, select, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_control.sv
// LEGv8 ALU control decode: ALUOp + opcode -> 4-bit select and a valid flag.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is used.
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    output logic [3:0]  select,
    output logic        valid
);

    // Decode table; anything not listed is reported as undecodable
    always_comb begin
        select = SEL_AND;
        valid  = 1'b0;
        case (alu_op)
            ALUOP_LDST: begin
                select = SEL_ADD;
                valid  = 1'b1;
            end
            ALUOP_CBZ: begin
                select = SEL_PASS_B;
                valid  = 1'b1;
            end
            ALUOP_RTYP: begin
                case (opcode)
                    OPC_ADD: begin select = SEL_ADD; valid = 1'b1; end
                    OPC_SUB: begin select = SEL_SUB; valid = 1'b1; end
                    OPC_AND: begin select = SEL_AND; valid = 1'b1; end
                    OPC_ORR: begin select = SEL_OR;  valid = 1'b1; end
                    default: begin select = SEL_AND; valid = 1'b0; end
                endcase
            end
            default: begin
                select = SEL_AND;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Drives operands/select to an external ALU, waits SETTLE_CYCLES, captures OUT.
// Latency: rsp_valid SETTLE_CYCLES+1 cycles after accept (1 cycle for undecodable ops).
// One op in flight; req_ready low until the response retires on rsp_ready.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [3:0]        sel_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              err_q;

    logic [3:0]        dec_sel;
    logic              dec_ok;
    logic              accept;
    logic              drive_done;

    alu_control u_ctrl (
        .alu_op (bus.alu_op),
        .opcode (bus.opcode),
        .select (dec_sel),
        .valid  (dec_ok)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake qualifiers
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        drive_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = dec_ok ? ST_DRIVE : ST_RESPOND;
                end
            end
            ST_DRIVE: begin
                if (cnt == 4'd0) begin
                    drive_done = 1'b1;
                    state_nxt  = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand/select latch, settle counter and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 4'b0000;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // Operands only move on a decodable accept; undecodable ops leave them alone
            if (accept && dec_ok) begin
                a_q   <= bus.req_a;
                b_q   <= bus.req_b;
                sel_q <= dec_sel;
                cnt   <= 4'(SETTLE_CYCLES - 1);
            end else if (state == ST_DRIVE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (drive_done) begin
                result_q <= bus.out;
                zero_q   <= (bus.out == '0);
                err_q    <= 1'b0;
            end else if (accept && !dec_ok) begin
                result_q <= '0;
                zero_q   <= 1'b0;
                err_q    <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = (state == ST_RESPOND);
    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.select     = sel_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural external ALU.
// Two instances: default settle time and SETTLE_CYCLES=1.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat;
    logic seen;

    always #5 clk = ~clk;

    alu_sequencer_if s0 ();
    alu_sequencer_if s1 ();

    alu_sequencer #(.SETTLE_CYCLES(2)) u_dut0 (.clk(clk), .reset(reset), .bus(s0.slave));
    alu_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(s1.slave));

    function automatic logic [63:0] alu_model(input logic [63:0] x, input logic [63:0] y,
                                              input logic [3:0] sel);
        case (sel)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return y;
            4'b1100: return ~(x | y);
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    assign s0.out = alu_model(s0.a, s0.b, s0.select);
    assign s1.out = alu_model(s1.a, s1.b, s1.select);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request on dut0 and count negedges until rsp_valid (bounded)
    task automatic issue(input logic [1:0] op, input logic [10:0] opc,
                         input logic [63:0] ra, input logic [63:0] rb, output int l);
        s0.alu_op = op;
        s0.opcode = opc;
        s0.req_a = ra;
        s0.req_b = rb;
        s0.req_valid = 1'b1;
        l = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            l++;
            s0.req_valid = 1'b0;
            if (s0.rsp_valid) break;
        end
    endtask

    task automatic retire(input string tag);
        s0.rsp_ready = 1'b1;
        @(negedge clk);
        s0.rsp_ready = 1'b0;
        check({tag, "_retire_vld"}, s0.rsp_valid, 0);
        check({tag, "_retire_rdy"}, s0.req_ready, 1);
    endtask

    initial begin
        s0.req_valid = 0; s0.alu_op = 0; s0.opcode = 0; s0.req_a = 0; s0.req_b = 0; s0.rsp_ready = 0;
        s1.req_valid = 0; s1.alu_op = 0; s1.opcode = 0; s1.req_a = 0; s1.req_b = 0; s1.rsp_ready = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_req_ready", s0.req_ready, 1);
        check("rst_rsp_valid", s0.rsp_valid, 0);
        check("rst_a", s0.a, 0);
        check("rst_b", s0.b, 0);
        check("rst_select", s0.select, 0);
        check("rst_result", s0.rsp_result, 0);
        check("rst_zero", s0.rsp_zero, 0);
        check("rst_err", s0.rsp_err, 0);

        // R-type ADD: 64 + 32
        issue(ALUOP_RTYP, OPC_ADD, 64'd64, 64'd32, lat);
        check("add_lat", lat, 3);
        check("add_select", s0.select, 4'b0010);
        check("add_result", s0.rsp_result, 96);
        check("add_zero", s0.rsp_zero, 0);
        check("add_err", s0.rsp_err, 0);

        // Hold response with a competing request pending
        s0.alu_op = ALUOP_RTYP; s0.opcode = OPC_SUB; s0.req_a = 64'd7; s0.req_b = 64'd9;
        s0.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_vld", s0.rsp_valid, 1);
            check("hold_result", s0.rsp_result, 96);
            check("hold_rdy", s0.req_ready, 0);
            check("hold_a", s0.a, 64);
        end
        // Retire with req_valid still high: no accept on the retire edge
        s0.rsp_ready = 1'b1;
        @(negedge clk);
        s0.rsp_ready = 1'b0;
        s0.req_valid = 1'b0;
        check("hold_retire_vld", s0.rsp_valid, 0);
        check("hold_retire_rdy", s0.req_ready, 1);
        check("hold_retire_a", s0.a, 64);

        // R-type SUB giving zero
        issue(ALUOP_RTYP, OPC_SUB, 64'd32, 64'd32, lat);
        check("sub_lat", lat, 3);
        check("sub_select", s0.select, 4'b0110);
        check("sub_result", s0.rsp_result, 0);
        check("sub_zero", s0.rsp_zero, 1);
        retire("sub");

        // Undecodable ALUOp 11: operands must not move
        issue(2'b11, OPC_ADD, 64'd5, 64'd7, lat);
        check("err_lat", lat, 1);
        check("err_err", s0.rsp_err, 1);
        check("err_result", s0.rsp_result, 0);
        check("err_zero", s0.rsp_zero, 0);
        check("err_a", s0.a, 32);
        check("err_b", s0.b, 32);
        check("err_select", s0.select, 4'b0110);
        retire("err");

        // R-type with an unknown opcode
        issue(ALUOP_RTYP, 11'b11111111111, 64'd1, 64'd2, lat);
        check("badopc_lat", lat, 1);
        check("badopc_err", s0.rsp_err, 1);
        retire("badopc");

        // AND, ORR and load/store ADD
        issue(ALUOP_RTYP, OPC_AND, 64'hF0F0, 64'hFF00, lat);
        check("and_select", s0.select, 4'b0000);
        check("and_result", s0.rsp_result, 64'hF000);
        retire("and");
        issue(ALUOP_RTYP, OPC_ORR, 64'hF0, 64'h0F, lat);
        check("or_select", s0.select, 4'b0001);
        check("or_result", s0.rsp_result, 64'hFF);
        retire("or");
        issue(ALUOP_LDST, 11'd0, 64'd5, 64'd7, lat);
        check("ldst_select", s0.select, 4'b0010);
        check("ldst_result", s0.rsp_result, 12);
        check("ldst_err", s0.rsp_err, 0);
        retire("ldst");

        // Short settle time on dut1: PASS B with zero
        s1.alu_op = ALUOP_CBZ; s1.opcode = 11'd0; s1.req_a = 64'd123; s1.req_b = 64'd0;
        s1.req_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            s1.req_valid = 1'b0;
            if (s1.rsp_valid) break;
        end
        check("cbz_lat", lat, 2);
        check("cbz_select", s1.select, 4'b0111);
        check("cbz_result", s1.rsp_result, 0);
        check("cbz_zero", s1.rsp_zero, 1);
        s1.rsp_ready = 1'b1;
        @(negedge clk);
        s1.rsp_ready = 1'b0;
        check("cbz_retire_rdy", s1.req_ready, 1);

        // Reset in the middle of DRIVE drops the op
        s0.alu_op = ALUOP_RTYP; s0.opcode = OPC_ADD; s0.req_a = 64'd11; s0.req_b = 64'd22;
        s0.req_valid = 1'b1;
        @(negedge clk);
        s0.req_valid = 1'b0;
        check("mid_accepted", s0.req_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_req_ready", s0.req_ready, 1);
        check("mid_rsp_valid", s0.rsp_valid, 0);
        check("mid_a", s0.a, 0);
        check("mid_b", s0.b, 0);
        check("mid_select", s0.select, 0);
        check("mid_result", s0.rsp_result, 0);
        check("mid_zero", s0.rsp_zero, 0);
        check("mid_err", s0.rsp_err, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s0.rsp_valid) seen = 1'b1;
        end
        check("mid_no_rsp", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
